chip_link_arbiter: RTL
======================

// Module: chip_link_arbiter
// PURPOSE
//  Egress scheduler for one mesh edge port (E/N/W/S) toward the inter-chip link.
//  - Buffers flits from CONNECT NoC edge routers in per-source FIFOs (credit flow control).
//  - Round-robin arbitrates the single link among those sources, with bounded bursts.
//  - Emits {src_idx, flit} words to the chip interface send path.
//  - Instantiated once per mesh edge port, between the NoC edge and chip_interface.
// PARAMETERS
//  FW        59  flit width
//  B         4   per-source FIFO depth, in flits; equals credits granted to each NoC router
//  CONNECT   2   number of NoC sources sharing this link (>=2)
//  BURST_MAX 4   max flits sent per grant before the arbiter rotates (>=1)
//  IW        derived: log2(CONNECT); width of the source index
// PORTS
//  clk                in   1            system clock
//  rst                in   1            synchronous, active-high reset
//  flit_in_wr_noc     in   CONNECT      per-source flit write strobe
//  flit_in_noc        in   FW*CONNECT   per-source flit; source j at [FW*(j+1)-1:FW*j]
//  credit_out_noc     out  CONNECT      1-cycle credit return pulse per source
//  send_fifo_full     in   1            chip interface cannot accept a word this cycle
//  connect_available  in   CONNECT      remote side can take traffic for source j
//  data_out_wr        out  1            data_out valid strobe
//  data_out           out  FW+IW        {src_idx[IW-1:0], flit[FW-1:0]}
//  grant_idx          out  IW           current grant, for debug
// BEHAVIOUR
//  Reset (synchronous, active-high)
//  - Clock and reset: single clock clk; synchronous, active-high reset rst.
//  - On rst: all FIFOs empty, state=IDLE, rr_ptr=0, burst_cnt=0.
//  - Outputs after rst: data_out_wr=0, data_out=0, credit_out_noc=0, grant_idx=0.
//  FIFO write
//  - flit_in_wr_noc[j]=1 pushes into FIFO j.
//  - Push and pop on the same FIFO in the same cycle are both honoured.
//  - Push to a full FIFO is a protocol violation: flit dropped, count unchanged.
//  Eligibility
//  - elig[j] = FIFO j non-empty AND connect_available[j].
//  FSM
//  - IDLE: if any elig, grant the first eligible index scanning rr_ptr, rr_ptr+1, ... (mod CONNECT).
//    Load grant, set burst_cnt=0, go to SEND. Otherwise stay in IDLE. No pop in IDLE.
//  - SEND, send_fifo_full=1: stall. No pop; state and burst_cnt held.
//  - SEND, elig[grant]=1 and !send_fifo_full: pop FIFO[grant], burst_cnt++.
//    If burst_cnt reaches BURST_MAX, or the FIFO becomes empty, go to IDLE with rr_ptr=grant+1 (wrap).
//  - SEND, elig[grant]=0: go to IDLE with rr_ptr=grant+1. No pop.
//  Output timing
//  - A pop in cycle N gives data_out_wr=1 and data_out={grant,head} in cycle N+1 (registered).
//  - credit_out_noc[grant]=1 is also driven in cycle N+1, for exactly one cycle.
//  Throughput and latency
//  - Minimum per-grant overhead: 1 IDLE cycle.
//  - Sustained rate is BURST_MAX flits per BURST_MAX+1 cycles.
//  - Latency from push to data_out_wr is at least 3 cycles (write, IDLE, pop, output).
//  Boundary conditions
//  - connect_available drops mid-burst: the burst ends the next cycle; no flit is lost.
//  - A push into the granted FIFO in the same cycle as its last pop does not extend the burst;
//    the FSM goes to IDLE.
//  - Pointer wrap: grant=CONNECT-1 rotates to rr_ptr=0.
//  - Reset asserted mid-burst: any FIFO contents are discarded; no credit pulses are issued for them.
// CONFIGURATION
//  LINK_ARB_OVF_CHK_EN
//  - Defined: adds output ovf_err (CONNECT bits).
//    Bit j is set, sticky, when a push hits full FIFO j. Cleared only by rst.
//  - Undefined: the port is absent. Overflowing pushes are silently dropped.
// TESTING
//  - Reset: hold rst 2 cycles with random inputs -> all outputs 0, no credit pulses.
//  - Single flit: CONNECT=2, push 0x1A5 on src1, all available
//    -> data_out={1'b1,0x1A5}, data_out_wr 3 cycles after the push; credit_out_noc=2'b10 on the same cycle.
//  - Fairness: both FIFOs full (B=4), BURST_MAX=2
//    -> output order src0,src0,src1,src1,src0,src0,src1,src1; 8 credit pulses total.
//  - Backpressure: send_fifo_full=1 for 5 cycles mid-burst -> no data_out_wr, no credits;
//    the burst resumes in order afterwards.
//  - Unavailable: connect_available=2'b01 with both FIFOs loaded
//    -> only src0 drains; src1 drains after its bit rises.
//  - Overflow (LINK_ARB_OVF_CHK_EN): 5 pushes to src0 with the link stalled
//    -> ovf_err=2'b01; after unstalling, exactly 4 flits are output.

Source files
------------

// File: rtl/chip_link_arbiter.sv
// Egress scheduler for one mesh edge port: per-source credit FIFOs and a round-robin,
// burst-bounded arbiter onto the link. Define LINK_ARB_OVF_CHK_EN to add ovf_err flags.

module chip_link_arbiter #(
  parameter int unsigned FW        = 59,
  parameter int unsigned B         = 4,
  parameter int unsigned CONNECT   = 2,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned IW        = $clog2(CONNECT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CONNECT-1:0]    flit_in_wr_noc,
  input  logic [FW*CONNECT-1:0] flit_in_noc,
  output logic [CONNECT-1:0]    credit_out_noc,
  input  logic                  send_fifo_full,
  input  logic [CONNECT-1:0]    connect_available,
  output logic                  data_out_wr,
  output logic [FW+IW-1:0]      data_out,
  output logic [IW-1:0]         grant_idx
`ifdef LINK_ARB_OVF_CHK_EN
  ,
  output logic [CONNECT-1:0]    ovf_err
`endif
);

  localparam int unsigned PW = (B > 1) ? $clog2(B) : 1;
  localparam int unsigned CW = $clog2(B + 1);
  localparam int unsigned BW = $clog2(BURST_MAX + 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [IW-1:0] pick, next_ptr, scan_idx;
  logic          found;

  logic [FW-1:0] mem_q    [CONNECT][B];
  logic [PW-1:0] wr_ptr_q [CONNECT];
  logic [PW-1:0] rd_ptr_q [CONNECT];
  logic [CW-1:0] cnt_q    [CONNECT];

  logic [CONNECT-1:0] full, push, elig, pop_vec;
  logic               pop, last_pop;
  logic [FW-1:0]      head;

  logic               dwr_q;
  logic [FW+IW-1:0]   dout_q;
  logic [CONNECT-1:0] credit_q;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(B - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int j = 0; j < CONNECT; j++) begin
      full[j]    = (cnt_q[j] == CW'(B));
      push[j]    = flit_in_wr_noc[j] && !full[j];
      elig[j]    = (cnt_q[j] != '0) && connect_available[j];
      pop_vec[j] = pop && (grant_q == IW'(j));
    end
  end

  // FIFO bookkeeping; a push into a full FIFO is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < CONNECT; j++) begin
        wr_ptr_q[j] <= '0;
        rd_ptr_q[j] <= '0;
        cnt_q[j]    <= '0;
      end
    end else begin
      for (int j = 0; j < CONNECT; j++) begin
        if (push[j]) wr_ptr_q[j] <= ptr_inc(wr_ptr_q[j]);
        if (pop_vec[j]) rd_ptr_q[j] <= ptr_inc(rd_ptr_q[j]);
        if (push[j] && !pop_vec[j]) begin
          cnt_q[j] <= cnt_q[j] + 1'b1;
        end else if (!push[j] && pop_vec[j]) begin
          cnt_q[j] <= cnt_q[j] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < CONNECT; j++) begin
      if (push[j]) mem_q[j][wr_ptr_q[j]] <= flit_in_noc[FW*j +: FW];
    end
  end

  assign head     = mem_q[grant_q][rd_ptr_q[grant_q]];
  assign last_pop = (cnt_q[grant_q] == CW'(1));
  assign next_ptr = (grant_q == IW'(CONNECT - 1)) ? '0 : grant_q + 1'b1;

  // First eligible source scanning upward from rr_ptr, with wrap.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int k = 0; k < CONNECT; k++) begin
      scan_idx = IW'((int'(rr_ptr_q) + k) % int'(CONNECT));
      if (!found && elig[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = pick;
          burst_d = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (!send_fifo_full) begin
          if (elig[grant_q]) begin
            burst_d = burst_q + 1'b1;
            // A push landing with the last pop does not extend the burst.
            if ((burst_q == BW'(BURST_MAX - 1)) || last_pop) begin
              state_d  = StIdle;
              rr_ptr_d = next_ptr;
            end
          end else begin
            state_d  = StIdle;
            rr_ptr_d = next_ptr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pop       = (state_q == StSend) && !send_fifo_full && elig[grant_q];
    grant_idx = grant_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwr_q    <= 1'b0;
      dout_q   <= '0;
      credit_q <= '0;
    end else begin
      dwr_q    <= pop;
      credit_q <= pop_vec;
      if (pop) dout_q <= {grant_q, head};
    end
  end

  assign data_out_wr    = dwr_q;
  assign data_out       = dout_q;
  assign credit_out_noc = credit_q;

`ifdef LINK_ARB_OVF_CHK_EN
  logic [CONNECT-1:0] ovf_q;

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_q | (flit_in_wr_noc & full);
  end

  assign ovf_err = ovf_q;
`endif

endmodule
